imem_sync: RTL and testbench

- Parametrised, synchronous successor to the combinational instruction store of the SimpleRISC core.
- Registered one-cycle fetch with valid, stall and flush controls for the pipelined fetch stage.
- Write port for loading programs at run time.
- Post-reset fill FSM that preloads every word with NOP, so no entry is ever undefined.

---
 rtl/imem_sync_if.sv | 28 ++
 rtl/imem_sync.sv | 99 +++++++++
 tb/tb_imem_sync.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/imem_sync_if.sv
// Fetch and program-load bus of the synchronous instruction memory.
// The fetch stage and loader act as master; the memory is the slave.
interface imem_sync_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              ready;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              stall;
   logic              flush;
   logic              fetch_valid;
   logic [DATA_W-1:0] instruction;
   logic              fetch_fault;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;

   modport master (
      input  ready, fetch_valid, instruction, fetch_fault,
      output fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data
   );

   modport slave (
      output ready, fetch_valid, instruction, fetch_fault,
      input  fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data
   );
endinterface

// File: rtl/imem_sync.sv
// Synchronous instruction memory: NOP fill after reset, registered one-cycle
// fetch with stall/flush, and a write-first program port.
module imem_sync #(
   parameter int                 DATA_W   = 32,
   parameter int                 DEPTH    = 256,
   parameter int                 ADDR_W   = 32,
   parameter logic [DATA_W-1:0]  NOP_WORD = 32'h6800_0000
) (
   input logic        clk,
   input logic        reset,
   imem_sync_if.slave bus
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [IDX_W-1:0]  fill_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              fetch_valid_q;
   logic              fetch_fault_q;
   logic [DATA_W-1:0] instruction_q;

   logic              fetch_in_range;
   logic              prog_in_range;
   logic              write_en;
   logic              bypass;
   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  prog_idx;

   // Range checks use the full address so out-of-range words never alias.
   assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_EXT;
   assign prog_in_range  = {1'b0, bus.prog_addr}  < DEPTH_EXT;
   assign fetch_idx      = bus.fetch_addr[IDX_W-1:0];
   assign prog_idx       = bus.prog_addr[IDX_W-1:0];
   assign write_en       = (state == ST_RUN) && bus.prog_we && prog_in_range;
   assign bypass         = write_en && (bus.prog_addr == bus.fetch_addr);

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_FILL;
         fill_ptr <= '0;
      end else if (state == ST_FILL) begin
         fill_ptr <= fill_ptr + IDX_W'(1);
         if (fill_ptr == LAST_IDX) state <= ST_RUN;
      end
   end

   // NOTE: the array has no reset branch; the fill sequence defines every word,
   // which keeps it mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_FILL)  mem[fill_ptr] <= NOP_WORD;
         else if (write_en)     mem[prog_idx] <= bus.prog_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         instruction_q <= NOP_WORD;
      end else if (state == ST_RUN) begin
         if (bus.flush) begin
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            instruction_q <= NOP_WORD;
         end else if (!bus.stall) begin
            if (bus.fetch_req && fetch_in_range) begin
               fetch_valid_q <= 1'b1;
               fetch_fault_q <= 1'b0;
               // Same-cycle write to the fetched word is forwarded (write-first).
               instruction_q <= bypass ? bus.prog_data : mem[fetch_idx];
            end else if (bus.fetch_req) begin
               fetch_valid_q <= 1'b1;
               fetch_fault_q <= 1'b1;
               instruction_q <= NOP_WORD;
            end else begin
               fetch_valid_q <= 1'b0;
               fetch_fault_q <= 1'b0;
               instruction_q <= NOP_WORD;
            end
         end
      end
   end

   assign bus.ready       = (state == ST_RUN);
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_fault = fetch_fault_q;
   assign bus.instruction = instruction_q;

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: a behavioural model predicts each cycle's
// fetch output, which is queued at drive time and compared after the edge.
module tb_imem_sync;

   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h6800_0000;

   typedef struct packed {
      logic        valid;
      logic        fault;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   imem_sync_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   imem_sync #(
      .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] model_mem [DEPTH];
   exp_t        model_out;
   exp_t        sb_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
      model_out = '{valid: 1'b0, fault: 1'b0, instr: NOP};
   endtask

   task automatic idle_inputs();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
      bus.prog_we    = 1'b0;
      bus.prog_addr  = '0;
      bus.prog_data  = '0;
   endtask

   // One RUN cycle: drive, predict, queue, clock, then pop and compare.
   task automatic drive_cycle(input string tag, input logic req, input logic [31:0] addr,
                              input logic stl, input logic fls, input logic we,
                              input logic [31:0] waddr, input logic [31:0] wdata);
      exp_t e;
      bus.fetch_req  = req;
      bus.fetch_addr = addr;
      bus.stall      = stl;
      bus.flush      = fls;
      bus.prog_we    = we;
      bus.prog_addr  = waddr;
      bus.prog_data  = wdata;
      if (we && waddr < DEPTH) model_mem[waddr[7:0]] = wdata;
      if (fls)            model_out = '{valid: 1'b0, fault: 1'b0, instr: NOP};
      else if (stl)       model_out = model_out;
      else if (req && addr < DEPTH)
                          model_out = '{valid: 1'b1, fault: 1'b0, instr: model_mem[addr[7:0]]};
      else if (req)       model_out = '{valid: 1'b1, fault: 1'b1, instr: NOP};
      else                model_out = '{valid: 1'b0, fault: 1'b0, instr: NOP};
      sb_q.push_back(model_out);
      @(posedge clk);
      #1;
      idle_inputs();
      e = sb_q.pop_front();
      check({tag, ".ready"}, 32'(bus.ready), 32'd1);
      check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(e.valid));
      check({tag, ".fault"}, 32'(bus.fetch_fault), 32'(e.fault));
      check({tag, ".instr"}, bus.instruction, e.instr);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      model_reset();
      check({tag, ".ready"}, 32'(bus.ready), 32'd0);
      check({tag, ".valid"}, 32'(bus.fetch_valid), 32'd0);
      check({tag, ".fault"}, 32'(bus.fetch_fault), 32'd0);
      check({tag, ".instr"}, bus.instruction, NOP);
      reset = 1'b0;
   endtask

   // Runs n fill cycles while presenting fetches and a write to word 0
   // (already filled), none of which may take effect.
   task automatic fill_cycles(input string tag, input int n);
      for (int k = 1; k <= n; k++) begin
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 32'd5;
         bus.prog_we    = (k >= 2);
         bus.prog_addr  = 32'd0;
         bus.prog_data  = 32'hDEAD_BEEF;
         @(posedge clk);
         #1;
         check($sformatf("%s.ready%0d", tag, k), 32'(bus.ready), 32'(k == DEPTH));
         check($sformatf("%s.valid%0d", tag, k), 32'(bus.fetch_valid), 32'd0);
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      apply_reset("rst");
      fill_cycles("fill", DEPTH);

      drive_cycle("fetch5",    1'b1, 32'd5,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("wr4",       1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 32'd4,   32'h4C40_0000);
      drive_cycle("fetch4",    1'b1, 32'd4,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("wf8",       1'b1, 32'd8,   1'b0, 1'b0, 1'b1, 32'd8,   32'hF800_0000);
      drive_cycle("wr44",      1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 32'd44,  32'h1234_5678);
      drive_cycle("fetch300",  1'b1, 32'd300, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("fetch44",   1'b1, 32'd44,  1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("wr266",     1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 32'd266, 32'hBAD0_0001);
      drive_cycle("fetch10",   1'b1, 32'd10,  1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("wr255",     1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 32'd255, 32'h0000_00FF);
      drive_cycle("fetch255",  1'b1, 32'd255, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("fetch256",  1'b1, 32'd256, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("idle",      1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);

      drive_cycle("pre_stall", 1'b1, 32'd4,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      for (int i = 0; i < 3; i++)
         drive_cycle($sformatf("stall%0d", i), 1'b1, 32'd8, 1'b1, 1'b0, 1'b1,
                     32'd12, 32'hAAAA_0001);
      drive_cycle("flush_stall", 1'b1, 32'd8, 1'b1, 1'b1, 1'b1, 32'd13, 32'hAAAA_0002);
      drive_cycle("fetch12",   1'b1, 32'd12,  1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("fetch13",   1'b1, 32'd13,  1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("flush_req", 1'b1, 32'd4,   1'b0, 1'b1, 1'b0, 32'd0,   32'd0);

      apply_reset("rst2");
      fill_cycles("part", 100);
      apply_reset("rst3");
      fill_cycles("refill", DEPTH);
      drive_cycle("re_fetch4", 1'b1, 32'd4,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("re_fetch0", 1'b1, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
      drive_cycle("re_fetch8", 1'b1, 32'd8,   1'b0, 1'b0, 1'b0, 32'd0,   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
